// File: rtl/proc_control_unit.sv
// -----------------------------------------------------------------------------
// proc_control_unit
//   Instruction sequencer for the 16-bit datapath (r0-r7, A, G, H, bus mux).
//   Latches a 9-bit instruction {op[8:6], rX[5:3], rY[2:0]} on run and steps
//   through T1..T3. Only state and ir are registered; every strobe is a
//   combinational decode of (state, ir), so the datapath captures on the
//   posedge that ends the step.
//
//   Optional feature: define PROC_CU_RETIRE_CNT_EN to add a 16-bit retired
//   instruction counter output (increments on every cycle with done=1).
//
// Ports
//   clk      in   system clock, posedge
//   rst      in   synchronous reset, active-high, priority over run
//   run      in   start request, sampled in IDLE or in the final step
//   din      in   instruction word / immediate pins
//   ir       out  latched instruction
//   bus_sel  out  mux select: 0-7 rN, N_REGS = din, N_REGS+1 = G
//   r_in     out  one-hot GP register write enable
//   a_in     out  A write enable
//   g_in     out  G write enable (ALU result)
//   h_in     out  H (display) write enable
//   alu_op   out  ir[8:6] during the G-capture step, else 0
//   busy     out  high in T1..T3
//   done     out  high during the final step of an instruction
//   tick     out  one-hot step: IDLE=0000, T1=0001, T2=0010, T3=0100
//   retired  out  (PROC_CU_RETIRE_CNT_EN only) retired instruction count
// -----------------------------------------------------------------------------
module proc_control_unit #(
   parameter int N_REGS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [8:0]        din,
   output logic [8:0]        ir,
   output logic [3:0]        bus_sel,
   output logic [N_REGS-1:0] r_in,
   output logic              a_in,
   output logic              g_in,
   output logic              h_in,
   output logic [2:0]        alu_op,
   output logic              busy,
   output logic              done,
`ifdef PROC_CU_RETIRE_CNT_EN
   output logic [15:0]       retired,
`endif
   output logic [3:0]        tick
);

   typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_e;

   typedef enum logic [2:0] {
      OP_DISP = 3'b000,
      OP_ADD  = 3'b001,
      OP_ADDI = 3'b010,
      OP_SUB  = 3'b011,
      OP_MUL  = 3'b100,
      OP_SRL  = 3'b101,
      OP_SLL  = 3'b110,
      OP_MOVI = 3'b111
   } op_e;

   localparam logic [3:0] SEL_DIN = 4'(N_REGS);
   localparam logic [3:0] SEL_G   = 4'(N_REGS + 1);

   state_e     state_q, state_d;
   logic [8:0] ir_q, ir_d;

   op_e        op;
   logic [2:0] rx, ry;

   assign op = op_e'(ir_q[8:6]);
   assign rx = ir_q[5:3];
   assign ry = ir_q[2:0];

   // Strobe decode for the current step.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves it unassigned, which would infer a latch.
      bus_sel = '0;
      r_in    = '0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      h_in    = 1'b0;
      alu_op  = '0;
      done    = 1'b0;
      unique case (state_q)
         S_T1: begin
            unique case (op)
               OP_DISP: begin
                  bus_sel = {1'b0, rx};
                  h_in    = 1'b1;
                  done    = 1'b1;
               end
               OP_MOVI: begin
                  bus_sel  = SEL_DIN;
                  r_in[rx] = 1'b1;
                  done     = 1'b1;
               end
               default: begin
                  bus_sel = {1'b0, rx};
                  a_in    = 1'b1;
               end
            endcase
         end
         S_T2: begin
            g_in   = 1'b1;
            alu_op = ir_q[8:6];
            unique case (op)
               OP_ADDI:         bus_sel = SEL_DIN;
               // Shifts take their amount from ir[2:0] inside the ALU, so
               // the bus is unused and left at 0.
               OP_SRL, OP_SLL:  bus_sel = '0;
               default:         bus_sel = {1'b0, ry};
            endcase
         end
         S_T3: begin
            bus_sel  = SEL_G;
            r_in[rx] = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

   // Next state: a new instruction is accepted only in IDLE or in the final
   // step, which gives back-to-back issue without an idle bubble.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      if (state_q == S_IDLE || done) begin
         if (run) begin
            ir_d    = din;
            state_d = S_T1;
         end else begin
            state_d = S_IDLE;
         end
      end else if (state_q == S_T1) begin
         state_d = S_T2;
      end else if (state_q == S_T2) begin
         state_d = S_T3;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops
      // update together from values sampled before the edge.
      if (rst) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

`ifdef PROC_CU_RETIRE_CNT_EN
   logic [15:0] retired_q, retired_d;

   // Wraps naturally from 0xFFFF to 0x0000.
   assign retired_d = retired_q + {15'd0, done};

   always_ff @(posedge clk) begin
      if (rst) retired_q <= '0;
      else     retired_q <= retired_d;
   end

   assign retired = retired_q;
`endif

   assign ir   = ir_q;
   assign busy = (state_q != S_IDLE);

   always_comb begin
      tick = 4'b0000;
      unique case (state_q)
         S_T1:    tick = 4'b0001;
         S_T2:    tick = 4'b0010;
         S_T3:    tick = 4'b0100;
         default: tick = 4'b0000;
      endcase
   end

endmodule

// File: tb/tb_proc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_proc_control_unit
//   Table-driven bench for proc_control_unit. Each vector row holds the inputs
//   applied before a posedge and the full output bundle expected just after
//   it. Hand-written sequences cover busy length and the retire counter
//   (the latter only when PROC_CU_RETIRE_CNT_EN is defined).
// -----------------------------------------------------------------------------
module tb_proc_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [8:0] din;
   logic [8:0] ir;
   logic [3:0] bus_sel;
   logic [7:0] r_in;
   logic       a_in, g_in, h_in;
   logic [2:0] alu_op;
   logic       busy, done;
   logic [3:0] tick;
`ifdef PROC_CU_RETIRE_CNT_EN
   logic [15:0] retired;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   proc_control_unit #(.N_REGS(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .din     (din),
      .ir      (ir),
      .bus_sel (bus_sel),
      .r_in    (r_in),
      .a_in    (a_in),
      .g_in    (g_in),
      .h_in    (h_in),
      .alu_op  (alu_op),
      .busy    (busy),
      .done    (done),
`ifdef PROC_CU_RETIRE_CNT_EN
      .retired (retired),
`endif
      .tick    (tick)
   );

   // {ir, bus_sel, r_in, a_in, g_in, h_in, alu_op, busy, done, tick}
   typedef struct {
      logic        rst;
      logic        run;
      logic [8:0]  din;
      logic [32:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic r, input logic ru, input logic [8:0] d,
                       input logic [8:0] e_ir, input logic [3:0] e_sel,
                       input logic [7:0] e_rin, input logic [2:0] e_agh,
                       input logic [2:0] e_alu, input logic e_busy,
                       input logic e_done, input logic [3:0] e_tick);
      vec_t v;
      v.rst = r;
      v.run = ru;
      v.din = d;
      v.exp = {e_ir, e_sel, e_rin, e_agh, e_alu, e_busy, e_done, e_tick};
      vecs.push_back(v);
   endtask

   function automatic logic [32:0] outs();
      return {ir, bus_sel, r_in, a_in, g_in, h_in, alu_op, busy, done, tick};
   endfunction

   initial begin
      int busy_cnt;
      int done_cnt;
      logic [32:0] strobe_ok;

      rst = 1'b1;
      run = 1'b1;
      din = 9'h1FF;

      //     rst  run  din     ir      sel   r_in   agh     alu  busy done tick
      // reset held with run=1
      push(1'b1, 1'b1, 9'h1FF, 9'h000, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      push(1'b1, 1'b1, 9'h1FF, 9'h000, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // MOV_I r2
      push(1'b0, 1'b1, 9'h1D0, 9'h1D0, 4'd8, 8'h04, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h1D0, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // ADD r1,r2
      push(1'b0, 1'b1, 9'h04A, 9'h04A, 4'd1, 8'h00, 3'b100, 3'd0, 1'b1, 1'b0, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h04A, 4'd2, 8'h00, 3'b010, 3'd1, 1'b1, 1'b0, 4'b0010);
      push(1'b0, 1'b0, 9'h000, 9'h04A, 4'd9, 8'h02, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0100);
      push(1'b0, 1'b0, 9'h000, 9'h04A, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // DISP r5 then SUB r0,r7 back-to-back; run during SUB T1 is ignored
      push(1'b0, 1'b1, 9'h028, 9'h028, 4'd5, 8'h00, 3'b001, 3'd0, 1'b1, 1'b1, 4'b0001);
      push(1'b0, 1'b1, 9'h0C7, 9'h0C7, 4'd0, 8'h00, 3'b100, 3'd0, 1'b1, 1'b0, 4'b0001);
      push(1'b0, 1'b1, 9'h1FF, 9'h0C7, 4'd7, 8'h00, 3'b010, 3'd3, 1'b1, 1'b0, 4'b0010);
      push(1'b0, 1'b0, 9'h000, 9'h0C7, 4'd9, 8'h01, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0100);
      push(1'b0, 1'b0, 9'h000, 9'h0C7, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // ADD_I r4 then MOV_I r7 issued from T3
      push(1'b0, 1'b1, 9'h0A3, 9'h0A3, 4'd4, 8'h00, 3'b100, 3'd0, 1'b1, 1'b0, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h0A3, 4'd8, 8'h00, 3'b010, 3'd2, 1'b1, 1'b0, 4'b0010);
      push(1'b0, 1'b0, 9'h000, 9'h0A3, 4'd9, 8'h10, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0100);
      push(1'b0, 1'b1, 9'h1F8, 9'h1F8, 4'd8, 8'h80, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h1F8, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // SRL r6 by 3
      push(1'b0, 1'b1, 9'h173, 9'h173, 4'd6, 8'h00, 3'b100, 3'd0, 1'b1, 1'b0, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h173, 4'd0, 8'h00, 3'b010, 3'd5, 1'b1, 1'b0, 4'b0010);
      push(1'b0, 1'b0, 9'h000, 9'h173, 4'd9, 8'h40, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0100);
      push(1'b0, 1'b0, 9'h000, 9'h173, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // SLL r1 by 7
      push(1'b0, 1'b1, 9'h18F, 9'h18F, 4'd1, 8'h00, 3'b100, 3'd0, 1'b1, 1'b0, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h18F, 4'd0, 8'h00, 3'b010, 3'd6, 1'b1, 1'b0, 4'b0010);
      push(1'b0, 1'b0, 9'h000, 9'h18F, 4'd9, 8'h02, 3'b000, 3'd0, 1'b1, 1'b1, 4'b0100);
      push(1'b0, 1'b0, 9'h000, 9'h18F, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      // MUL r3,r3 aborted by reset in T2 (reset wins over run)
      push(1'b0, 1'b1, 9'h11B, 9'h11B, 4'd3, 8'h00, 3'b100, 3'd0, 1'b1, 1'b0, 4'b0001);
      push(1'b0, 1'b0, 9'h000, 9'h11B, 4'd3, 8'h00, 3'b010, 3'd4, 1'b1, 1'b0, 4'b0010);
      push(1'b1, 1'b1, 9'h1D0, 9'h000, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);
      push(1'b0, 1'b0, 9'h000, 9'h000, 4'd0, 8'h00, 3'b000, 3'd0, 1'b0, 1'b0, 4'b0000);

      foreach (vecs[i]) begin
         rst = vecs[i].rst;
         run = vecs[i].run;
         din = vecs[i].din;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
         // At most one write strobe class, r_in one-hot or zero.
         strobe_ok = 33'((($countones({|r_in, a_in, g_in, h_in}) <= 1) && $onehot0(r_in)) ? 1 : 0);
         check($sformatf("strobe_excl%0d", i), strobe_ok, 33'd1);
      end

      // ADD r3,r3: busy for exactly 3 cycles with one done; bounded wait.
      rst = 1'b0;
      run = 1'b1;
      din = 9'h05B;
      @(posedge clk);
      #1;
      run = 1'b0;
      din = 9'h000;
      busy_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         @(posedge clk);
         #1;
      end
      check("busy_len", 33'(busy_cnt), 33'd3);
      check("done_cnt", 33'(done_cnt), 33'd1);

`ifdef PROC_CU_RETIRE_CNT_EN
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("retired_rst", 33'(retired), 33'd0);
      rst = 1'b0;
      run = 1'b1;
      din = 9'h028;
      // Back-to-back DISP: each edge after the first retires one instruction.
      for (int c = 0; c < 65536; c++) @(posedge clk);
      #1;
      check("retired_ffff", 33'(retired), 33'h0FFFF);
      run = 1'b0;
      @(posedge clk);
      #1;
      check("retired_wrap", 33'(retired), 33'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
